calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Sequencing FSM for the calculator datapath. It walks a configurable read address window across the two SRAM read ports (port 1) and presents each operand pair to the 32-bit adder. It steers each sum into the lower or upper half of the 64-bit result buffer, then writes each completed 64-bit result through the SRAM write ports (port 0) across a configurable write window. Software starts it with a one-cycle start pulse. It reports completion, or an error, with a one-cycle done pulse.

Parameters:
ADDR_W, 9, SRAM word address width (512 words).
DATA_W, 32, operand/sum width; result buffer is 2*DATA_W.

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  synchronous, active-high reset
start_i  in  1  start pulse; sampled only in IDLE
read_start_addr  in  ADDR_W  first operand address
read_end_addr  in  ADDR_W  last operand address (inclusive)
write_start_addr  in  ADDR_W  first result address
write_end_addr  in  ADDR_W  last result address (inclusive)
rd_csb_o  out  1  port-1 chip select, active low, both SRAMs
rd_addr_o  out  ADDR_W  port-1 address, both SRAMs
r_data_a_i  in  DATA_W  SRAM_A dout1 (operand A)
r_data_b_i  in  DATA_W  SRAM_B dout1 (operand B)
op_a_o  out  DATA_W  adder operand A (registered)
op_b_o  out  DATA_W  adder operand B (registered)
buf_load_o  out  1  result buffer capture strobe for sum
buffer_control_o  out  1  1 = upper half, 0 = lower half
buff_result_i  in  2*DATA_W  result buffer contents
wr_csb_o  out  1  port-0 chip select, active low
wr_web_o  out  1  port-0 write enable, active low
wr_addr_o  out  ADDR_W  port-0 address
w_data_o  out  2*DATA_W  [63:32] to SRAM_A din0, [31:0] to SRAM_B din0
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky error flag; cleared on next accepted start

Behaviour:
- Reset values: rd_csb_o=1, wr_csb_o=1, wr_web_o=1, all addresses 0, op_a_o=op_b_o=0, buf_load_o=0, buffer_control_o=0, w_data_o=0, busy_o=0, done_o=0, err_o=0. Internal state: rd_ptr=0, wr_ptr=0, half=0, FSM=IDLE.
- Reset asserted in any state returns to IDLE next edge. No SRAM write is issued in the reset cycle or after it.
- States: IDLE, RD_REQ, RD_WAIT, ACCUM, FILL, WR, DONE.
- IDLE: when start_i=1, clear err_o.
  - If read_start_addr > read_end_addr or write_start_addr > write_end_addr: set err_o and go to DONE.
  - Otherwise load rd_ptr=read_start_addr, wr_ptr=write_start_addr, half=0, and go to RD_REQ.
- start_i outside IDLE is ignored.
- RD_REQ: rd_csb_o=0, rd_addr_o=rd_ptr. Go to RD_WAIT.
- RD_WAIT: SRAM data is valid in this cycle. Register op_a_o<=r_data_a_i and op_b_o<=r_data_b_i. Go to ACCUM.
- ACCUM: buf_load_o=1, buffer_control_o=half. The buffer captures the adder sum at the end of the cycle.
  - If half=0 and rd_ptr!=read_end_addr: half<=1, rd_ptr++, go to RD_REQ.
  - If half=0 and rd_ptr==read_end_addr: go to FILL (odd count).
  - If half=1: go to WR.
- FILL: op_a_o=op_b_o=0 were registered on entry. Drive buf_load_o=1 and buffer_control_o=1, so the upper half becomes 0. Go to WR.
- WR: wr_csb_o=0, wr_web_o=0, wr_addr_o=wr_ptr, w_data_o=buff_result_i. Set half<=0.
  - Last operand consumed (rd_ptr==read_end_addr at the time of the final ACCUM): go to DONE.
  - Else if wr_ptr==write_end_addr: set err_o (write window overflow) and go to DONE.
  - Else: wr_ptr++, rd_ptr++, go to RD_REQ.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Read and write ports are never active in the same cycle.
- Pointer comparisons use equality against the end address, so an end of 2^ADDR_W-1 does not wrap. A single-address window (start==end) is legal.
- Latency: N operands need ceil(N/2) writes. An even N costs 3N + N/2 + 2 cycles from start to done (IDLE accept cycle plus DONE).

Test Plan:
- Read 0..3, A={1,2,3,4}, B={10,20,30,40}; write 100..101 -> SRAM[100]={22,11}, SRAM[101]={44,33} as {upper,lower}; one done_o pulse; err_o=0; busy_o high for 15 cycles.
- Odd count: read 5..7, A=B={1,2,3}; write 200..201 -> SRAM[200]={4,2}, SRAM[201]={0,6}; err_o=0.
- Overflow: read 0..5, write 50..50 -> only SRAM[50] written (pair 0,1); err_o=1; done_o pulses; no further read issued.
- Invalid range: read_start=9, read_end=3 -> no rd/wr chip select ever low; done_o pulses two cycles after start; err_o=1. A following valid start clears err_o.
- Reset mid-operation: assert rst_i during the second RD_WAIT -> next cycle all outputs at reset values, no write occurs; a new start runs normally.
- Boundary: read 511..511, write 511..511 -> SRAM[511]={0,A+B}, no address wrap; start_i held high during busy does not retrigger.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: walks operand pairs from the SRAM read ports through the
// adder into the 64-bit result buffer, then writes each result back.
module calc_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   read_start_addr,
  input  logic [ADDR_W-1:0]   read_end_addr,
  input  logic [ADDR_W-1:0]   write_start_addr,
  input  logic [ADDR_W-1:0]   write_end_addr,
  output logic                rd_csb_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [DATA_W-1:0]   r_data_a_i,
  input  logic [DATA_W-1:0]   r_data_b_i,
  output logic [DATA_W-1:0]   op_a_o,
  output logic [DATA_W-1:0]   op_b_o,
  output logic                buf_load_o,
  output logic                buffer_control_o,
  input  logic [2*DATA_W-1:0] buff_result_i,
  output logic                wr_csb_o,
  output logic                wr_web_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [2*DATA_W-1:0] w_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, ACCUM, FILL, WR, DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              half_q, half_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;

  logic bad_range;

  assign bad_range = (read_start_addr > read_end_addr) ||
                     (write_start_addr > write_end_addr);

  assign op_a_o = op_a_q;
  assign op_b_o = op_b_q;
  assign err_o  = err_q;

  // State, pointers, operand registers and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      half_q   <= 1'b0;
      err_q    <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      half_q   <= half_d;
      err_q    <= err_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  // Next-state and port strobes; the read and write ports own
  // disjoint states so they can never be active together
  always_comb begin
    state_d          = state_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    half_d           = half_q;
    err_d            = err_q;
    op_a_d           = op_a_q;
    op_b_d           = op_b_q;
    rd_csb_o         = 1'b1;
    rd_addr_o        = '0;
    buf_load_o       = 1'b0;
    buffer_control_o = 1'b0;
    wr_csb_o         = 1'b1;
    wr_web_o         = 1'b1;
    wr_addr_o        = '0;
    w_data_o         = '0;
    busy_o           = (state_q != IDLE);
    done_o           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (bad_range) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rd_ptr_d = read_start_addr;
            wr_ptr_d = write_start_addr;
            half_d   = 1'b0;
            state_d  = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        rd_csb_o  = 1'b0;
        rd_addr_o = rd_ptr_q;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        op_a_d  = r_data_a_i;
        op_b_d  = r_data_b_i;
        state_d = ACCUM;
      end
      ACCUM: begin
        buf_load_o       = 1'b1;
        buffer_control_o = half_q;
        if (half_q) begin
          state_d = WR;
        end else if (rd_ptr_q != read_end_addr) begin
          half_d   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = RD_REQ;
        end else begin
          op_a_d  = '0;
          op_b_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        buf_load_o       = 1'b1;
        buffer_control_o = 1'b1;
        state_d          = WR;
      end
      WR: begin
        wr_csb_o  = 1'b0;
        wr_web_o  = 1'b0;
        wr_addr_o = wr_ptr_q;
        w_data_o  = buff_result_i;
        half_d    = 1'b0;
        if (rd_ptr_q == read_end_addr) begin
          state_d = DONE;
        end else if (wr_ptr_q == write_end_addr) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = RD_REQ;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: SRAM, adder and result buffer models around the
// sequencer, checked against a pair-sum reference model.
module tb_calc_sequencer;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] rsa, rea, wsa, wea;
  logic rd_csb, wr_csb, wr_web;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rda = '0;
  logic [DW-1:0] rdb = '0;
  logic [DW-1:0] opa, opb;
  logic bl, bc, busy, done, err;
  logic [2*DW-1:0] bres = '0;
  logic [2*DW-1:0] wdata;

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];
  logic [AW+2*DW-1:0] wr_log [$];

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int clash_cnt = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .read_start_addr(rsa), .read_end_addr(rea),
    .write_start_addr(wsa), .write_end_addr(wea),
    .rd_csb_o(rd_csb), .rd_addr_o(rd_addr),
    .r_data_a_i(rda), .r_data_b_i(rdb),
    .op_a_o(opa), .op_b_o(opb),
    .buf_load_o(bl), .buffer_control_o(bc),
    .buff_result_i(bres),
    .wr_csb_o(wr_csb), .wr_web_o(wr_web),
    .wr_addr_o(wr_addr), .w_data_o(wdata),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  // SRAM read port, adder + result buffer, write logging, event counters
  always @(posedge clk) begin
    if (!rd_csb) begin
      rda <= mem_a[rd_addr];
      rdb <= mem_b[rd_addr];
      rd_cnt <= rd_cnt + 1;
    end
    if (bl) begin
      if (bc) bres[63:32] <= opa + opb;
      else    bres[31:0]  <= opa + opb;
    end
    if (!wr_csb && !wr_web) wr_log.push_back({wr_addr, wdata});
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!rd_csb && !wr_csb) clash_cnt <= clash_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_rd_csb"}, rd_csb, 1);
    chk({t, "_wr_csb"}, wr_csb, 1);
    chk({t, "_wr_web"}, wr_web, 1);
    chk({t, "_addrs"}, {rd_addr, wr_addr}, 0);
    chk({t, "_ops"}, {opa, opb}, 0);
    chk({t, "_buf"}, {bl, bc}, 0);
    chk({t, "_wdata"}, wdata, 0);
    chk({t, "_flags"}, {busy, done, err}, 0);
  endtask

  task automatic run(input int rs, input int re, input int ws,
                     input int we, input int hold);
    int r0, d0, b0, w0, c0;
    int n, w, cons, nwr, fill, xbusy;
    bit inv, xerr, seen;
    logic [DW-1:0] lo, hi;
    logic [AW-1:0] xa;
    @(negedge clk);
    rsa = rs[AW-1:0];
    rea = re[AW-1:0];
    wsa = ws[AW-1:0];
    wea = we[AW-1:0];
    start = 1'b1;
    r0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt;
    w0 = wr_log.size(); c0 = clash_cnt;
    inv = (rs > re) || (ws > we);
    n = re - rs + 1;
    w = we - ws + 1;
    cons = inv ? 0 : ((n < 2 * w) ? n : 2 * w);
    nwr = (cons + 1) / 2;
    fill = cons % 2;
    xerr = inv || (n > 2 * w);
    xbusy = inv ? 1 : 3 * cons + nwr + fill + 1;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) chk("err_at_accept", err, inv);
      if (c + 1 >= hold) start = 1'b0;
      if (done_cnt != d0) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("err", err, xerr);
    chk("reads", rd_cnt - r0, cons);
    chk("writes", wr_log.size() - w0, nwr);
    chk("busy_cycles", busy_cnt - b0, xbusy);
    chk("port_clash", clash_cnt - c0, 0);
    for (int k = 0; k < nwr && w0 + k < wr_log.size(); k++) begin
      xa = AW'(ws + k);
      lo = mem_a[rs + 2 * k] + mem_b[rs + 2 * k];
      hi = (2 * k + 1 < cons) ?
           mem_a[rs + 2 * k + 1] + mem_b[rs + 2 * k + 1] : '0;
      chk("write_entry", wr_log[w0 + k], {xa, hi, lo});
    end
  endtask

  initial begin
    int rs, re, ws, we, r0, w0;
    bit got;
    rst = 1'b1; start = 1'b0;
    rsa = '0; rea = '0; wsa = '0; wea = '0;
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(10 * (i + 1));
    end
    run(0, 3, 100, 101, 0);
    chk("t1_w100", wr_log[wr_log.size() - 2], {9'd100, 32'd22, 32'd11});
    chk("t1_w101", wr_log[wr_log.size() - 1], {9'd101, 32'd44, 32'd33});

    for (int i = 0; i < 3; i++) begin
      mem_a[5 + i] = DW'(i + 1);
      mem_b[5 + i] = DW'(i + 1);
    end
    run(5, 7, 200, 201, 0);
    chk("t2_w201", wr_log[wr_log.size() - 1], {9'd201, 32'd0, 32'd6});

    run(0, 5, 50, 50, 0);
    run(9, 3, 20, 30, 0);
    run(10, 11, 20, 20, 0);

    @(negedge clk);
    rsa = 9'd0; rea = 9'd3; wsa = 9'd100; wea = 9'd101;
    start = 1'b1;
    r0 = rd_cnt; w0 = wr_log.size();
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_cnt - r0 == 2) got = 1;
    end
    chk("rst_reach", got, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_writes", wr_log.size() - w0, 0);
    chk("midrst_idle", busy, 0);
    run(0, 3, 100, 101, 0);

    mem_a[511] = $urandom;
    mem_b[511] = $urandom;
    run(511, 511, 511, 511, 4);

    for (int i = 0; i < 12; i++) begin
      rs = $urandom_range(0, 500);
      re = rs + $urandom_range(0, 8);
      ws = $urandom_range(0, 505);
      we = ws + $urandom_range(0, 4);
      if (i % 5 == 4) begin
        if (i % 2 == 0) re = rs - 1;
        else we = ws - 1;
        if (re < 0) re = rs + 1;
        if (we < 0) we = ws + 1;
      end
      run(rs, re, ws, we, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
